op1_sched: RTL and testbench
============================

Name: op1_sched

Overview:
- Sequencer for the op1 16-tap weighted-sum stage (16 x 8-bit data, 16 x 2-bit weight codes, 13-bit registered sum).
- Holds a table of per-kernel weight-code vectors and accepts one 16-sample frame at a time.
- For each active kernel it drives op1 with the frame and that kernel's codes, waits the op1 latency, and captures the sum.
- Corrects the one's-complement bias of negated taps and returns one result per kernel over a valid/ready port.

Parameters:
NUM_KERNEL, 4, number of weight-code vectors in the table (1..16); KW = max(1, clog2(NUM_KERNEL))
OP_LAT, 1, op1 latency in cycles from ctrl/data presented to data_out valid (1..4)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high reset
cfg_we  in  1  write one weight-code vector
cfg_kernel  in  KW  target kernel index for cfg_we
cfg_wdata  in  32  tap i code at bits [2i+1:2i]; 00 = x1, 01 = x2, 1x = negate
cfg_nk_we  in  1  write active kernel count
cfg_nk  in  KW+1  active kernel count, legal range 1..NUM_KERNEL
cfg_err  out  1  one-cycle pulse when a config write is rejected
in_valid  in  1  frame offered
in_ready  out  1  frame accepted when in_valid && in_ready
frame_in  in  128  sample i at bits [8i+7:8i]
op_data_out  out  128  to op1 data0..15_in, same packing as frame_in
op_ctrl_out  out  32  to op1 ctrl0..15_in, same packing as cfg_wdata
op_result_in  in  13  from op1 data_out
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  13  corrected sum
res_kernel  out  KW  kernel index of res_data
res_last  out  1  result belongs to the last active kernel of the frame
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset, synchronous, wins over every other input in any state, including mid-frame:
  - state = IDLE; all weight vectors = 0 (all x1); nk = 1.
  - op_data_out, op_ctrl_out, res_data, res_kernel = 0.
  - res_valid, res_last, busy, cfg_err = 0.
  - in_ready = 0 while reset is high.
- State machine:
  - IDLE: in_ready = 1. On accept, register frame_in into op_data_out, load W[0] into op_ctrl_out, set k = 0, go to ISSUE.
  - ISSUE: one cycle; op1 samples its inputs at the end of this cycle; go to WAIT with wait counter = OP_LAT.
  - WAIT: counts down. In the last WAIT cycle (OP_LAT cycles after ISSUE), at the clock edge, capture res_data = (op_result_in + n_neg) mod 2^13, res_kernel = k, res_last = (k == nk-1), res_valid = 1; go to OUT.
  - n_neg = count of taps in op_ctrl_out with bit1 = 1 (0..16).
  - OUT: hold res_valid, res_data, res_kernel and res_last stable until res_ready.
    - On handshake with k < nk-1: k += 1, load W[k+1] into op_ctrl_out, go to ISSUE.
    - On handshake with k = nk-1: go to IDLE.
    - res_valid drops in the cycle after the handshake unless a new capture occurs.
- op_data_out is stable for the entire frame. op_ctrl_out is stable from ISSUE through the capture cycle.
- Timing, OP_LAT = 1, res_ready held high:
  - accept in cycle c0 gives res_valid first in cycle c0+3 (c0+2+OP_LAT in general);
  - next kernel's result follows every 2+OP_LAT cycles;
  - in_ready returns in the cycle after the last handshake.
- Config writes:
  - Accepted only in IDLE. cfg_we or cfg_nk_we in any other state is ignored and cfg_err = 1 for one cycle.
  - cfg_nk = 0 or cfg_nk > NUM_KERNEL is rejected: cfg_err pulse, nk unchanged.
  - cfg_kernel >= NUM_KERNEL is rejected: cfg_err pulse.
  - cfg_we and cfg_nk_we together are both processed independently; cfg_err pulses if either is rejected.
- Write in the accept cycle:
  - cfg_we to kernel 0 in the same cycle as a frame accept forwards cfg_wdata directly into op_ctrl_out.
  - cfg_nk_we in the accept cycle applies to that frame.
- op_result_in is ignored outside the capture cycle.
- Correction arithmetic is unsigned 13-bit wrap-around; no saturation.

Test Plan:
- Reset defaults, stub op1 returns 13'd100 -> one frame accepted; exactly one result: res_data = 100, res_kernel = 0, res_last = 1; res_valid first high 3 cycles after accept; op_ctrl_out = 0.
- nk = 3; W[0] = 0, W[1] = all 01, W[2] = all 10; stub returns 13'd500 each time -> res_data = 500, 500, 516; res_kernel 0, 1, 2; res_last only on the third; in_ready high again in the cycle after the third handshake.
- Backpressure: res_ready low for 5 cycles in OUT -> res_valid, res_data and res_kernel stable; op_ctrl_out unchanged; in_ready = 0; no new ISSUE.
- Wrap: W[0] = 16 x 10; stub returns 13'h1FFA -> res_data = 13'h000A.
- Config guards:
  - cfg_we while busy -> cfg_err pulses 1 cycle, table unchanged.
  - cfg_nk = 0 in IDLE -> cfg_err pulse, nk unchanged.
  - cfg_we kernel 0 = 32'h55555555 in the accept cycle -> op_ctrl_out = 32'h55555555 at ISSUE.
- Reset asserted in WAIT with nk = 2 -> next cycle IDLE, res_valid = 0, op_ctrl_out = 0, nk = 1, table cleared; a following frame yields a single result using x1 codes.

Source files
------------

// File: rtl/op1_sched.sv
// op1_sched: drives the op1 16-tap weighted-sum stage once per active
// kernel for each accepted frame and returns bias-corrected sums.
module op1_sched #(
  parameter int NUM_KERNEL = 4,
  parameter int OP_LAT     = 1,
  parameter int KW         = (NUM_KERNEL > 1) ? $clog2(NUM_KERNEL) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic [KW-1:0] cfg_kernel,
  input  logic [31:0]   cfg_wdata,
  input  logic          cfg_nk_we,
  input  logic [KW:0]   cfg_nk,
  output logic          cfg_err,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  frame_in,
  output logic [127:0]  op_data_out,
  output logic [31:0]   op_ctrl_out,
  input  logic [12:0]   op_result_in,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [12:0]   res_data,
  output logic [KW-1:0] res_kernel,
  output logic          res_last,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUT
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   w_q [NUM_KERNEL];
  logic [31:0]   w_d [NUM_KERNEL];
  logic [KW:0]   nk_q, nk_d;
  logic [KW-1:0] k_q, k_d;
  logic [KW-1:0] kn;
  logic [2:0]    cnt_q, cnt_d;
  logic [127:0]  data_q, data_d;
  logic [31:0]   ctrl_q, ctrl_d;
  logic          rv_q, rv_d;
  logic [12:0]   rd_q, rd_d;
  logic [KW-1:0] rk_q, rk_d;
  logic          rl_q, rl_d;
  logic          err_q, err_d;
  logic [4:0]    nneg;
  logic          k_last;
  logic          kern_ok;
  logic          nk_ok;

  assign kn      = k_q + KW'(1);
  assign k_last  = ({1'b0, k_q} == (nk_q - 1'b1));
  assign kern_ok = ({1'b0, cfg_kernel} < (KW+1)'(NUM_KERNEL));
  assign nk_ok   = (cfg_nk != '0) &&
                   (cfg_nk <= (KW+1)'(NUM_KERNEL));

  assign in_ready    = (state_q == S_IDLE) && !reset;
  assign busy        = (state_q != S_IDLE);
  assign cfg_err     = err_q;
  assign op_data_out = data_q;
  assign op_ctrl_out = ctrl_q;
  assign res_valid   = rv_q;
  assign res_data    = rd_q;
  assign res_kernel  = rk_q;
  assign res_last    = rl_q;

  // Count negated taps; each one's-complement tap is one short.
  always_comb begin
    nneg = '0;
    for (int i = 0; i < 16; i++) begin
      nneg = nneg + {4'b0, ctrl_q[2*i+1]};
    end
  end

  // Next-state, config handling and result capture.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    nk_d    = nk_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    rv_d    = rv_q;
    rd_d    = rd_q;
    rk_d    = rk_q;
    rl_d    = rl_q;
    err_d   = 1'b0;

    if (state_q == S_IDLE) begin
      if (cfg_we) begin
        if (kern_ok) w_d[cfg_kernel] = cfg_wdata;
        else         err_d = 1'b1;
      end
      if (cfg_nk_we) begin
        if (nk_ok) nk_d = cfg_nk;
        else       err_d = 1'b1;
      end
    end else if (cfg_we || cfg_nk_we) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d  = frame_in;
          ctrl_d  = (cfg_we && cfg_kernel == '0) ?
                    cfg_wdata : w_q[0];
          k_d     = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = 3'(OP_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 3'd1) begin
          rd_d    = op_result_in + {8'b0, nneg};
          rk_d    = k_q;
          rl_d    = k_last;
          rv_d    = 1'b1;
          state_d = S_OUT;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_OUT: begin
        if (res_ready) begin
          rv_d = 1'b0;
          if (k_last) begin
            state_d = S_IDLE;
          end else begin
            k_d     = kn;
            ctrl_d  = w_q[kn];
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything mid-frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      for (int i = 0; i < NUM_KERNEL; i++) begin
        w_q[i] <= '0;
      end
      nk_q   <= (KW+1)'(1);
      k_q    <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      ctrl_q <= '0;
      rv_q   <= 1'b0;
      rd_q   <= '0;
      rk_q   <= '0;
      rl_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      nk_q    <= nk_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
      rk_q    <= rk_d;
      rl_q    <= rl_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_op1_sched.sv
// tb_op1_sched: scoreboard bench for op1_sched with an op1 stub
// and a signed-arithmetic reference model.
module tb_op1_sched;
  localparam int NK = 4;
  localparam int KW = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_we = 1'b0;
  logic [KW-1:0] cfg_kernel = '0;
  logic [31:0]   cfg_wdata = '0;
  logic          cfg_nk_we = 1'b0;
  logic [KW:0]   cfg_nk = '0;
  logic          cfg_err;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [127:0]  frame_in = '0;
  logic [127:0]  op_data_out;
  logic [31:0]   op_ctrl_out;
  logic [12:0]   op_result_in;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [12:0]   res_data;
  logic [KW-1:0] res_kernel;
  logic          res_last;
  logic          busy;

  op1_sched #(.NUM_KERNEL(NK), .OP_LAT(1)) dut (
    .clock(clock), .reset(reset),
    .cfg_we(cfg_we), .cfg_kernel(cfg_kernel),
    .cfg_wdata(cfg_wdata), .cfg_nk_we(cfg_nk_we),
    .cfg_nk(cfg_nk), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready),
    .frame_in(frame_in), .op_data_out(op_data_out),
    .op_ctrl_out(op_ctrl_out), .op_result_in(op_result_in),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_kernel(res_kernel),
    .res_last(res_last), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [12:0]   d;
    logic [KW-1:0] k;
    logic          l;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mw[NK];
  int          mnk;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          rise_cyc = -1;
  bit          rv_prev = 1'b0;
  bit          last_pend = 1'b0;
  bit          rand_rdy = 1'b0;
  bit          stub_const = 1'b0;
  logic [12:0] stub_val = '0;
  logic [12:0] stub_q = '0;

  always @(posedge clock) cyc <= cyc + 1;

  // op1 stub: latency 1, one's-complement negation.
  function automatic logic [12:0] op1_fn(logic [127:0] d,
                                         logic [31:0] c);
    logic [12:0] s;
    logic [12:0] v;
    s = '0;
    for (int i = 0; i < 16; i++) begin
      v = {5'b0, d[8*i +: 8]};
      if (c[2*i+1])    s = s + ~v;
      else if (c[2*i]) s = s + (v << 1);
      else             s = s + v;
    end
    return s;
  endfunction

  always @(posedge clock)
    stub_q <= stub_const ? stub_val : op1_fn(op_data_out, op_ctrl_out);
  assign op_result_in = stub_q;

  // Reference: true signed weighted sum (or constant + bias) mod 2^13.
  function automatic logic [12:0] ref_fn(logic [127:0] d,
                                         logic [31:0] c);
    int s;
    int x;
    s = 0;
    if (stub_const) begin
      s = int'(stub_val);
      for (int i = 0; i < 16; i++) if (c[2*i+1]) s = s + 1;
    end else begin
      for (int i = 0; i < 16; i++) begin
        x = int'(d[8*i +: 8]);
        if (c[2*i+1])    s = s - x;
        else if (c[2*i]) s = s + 2 * x;
        else             s = s + x;
      end
    end
    return 13'(s);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", nm);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset;
    for (int i = 0; i < NK; i++) mw[i] = '0;
    mnk = 1;
  endtask

  task automatic send_frame(input logic [127:0] f);
    int n;
    exp_t e;
    n = 0;
    frame_in = f;
    in_valid = 1'b1;
    while (!in_ready && n < 500) begin
      tick;
      n++;
    end
    if (!in_ready) begin
      fail_now("accept_wait");
      in_valid = 1'b0;
      return;
    end
    for (int k = 0; k < mnk; k++) begin
      e.d = ref_fn(f, mw[k]);
      e.k = KW'(k);
      e.l = (k == mnk - 1);
      sb.push_back(e);
    end
    acc_cyc = cyc;
    tick;
    in_valid  = 1'b0;
    cfg_we    = 1'b0;
    cfg_nk_we = 1'b0;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (!(in_ready && sb.size() == 0) && n < 2000) begin
      tick;
      n++;
    end
    if (n >= 2000) begin
      fail_now("idle_wait");
      sb.delete();
    end
  endtask

  // Config write in IDLE; model applies the legality rules.
  task automatic cfg_idle(input bit we, input int k,
                          input logic [31:0] wd,
                          input bit nwe, input int n);
    bit e;
    e = 1'b0;
    cfg_we     = we;
    cfg_kernel = KW'(k);
    cfg_wdata  = wd;
    cfg_nk_we  = nwe;
    cfg_nk     = (KW+1)'(n);
    if (we) begin
      if (k < NK) mw[k] = wd;
      else        e = 1'b1;
    end
    if (nwe) begin
      if (n >= 1 && n <= NK) mnk = n;
      else                   e = 1'b1;
    end
    tick;
    cfg_we    = 1'b0;
    cfg_nk_we = 1'b0;
    chk("cfg_err", 128'(cfg_err), 128'(e));
  endtask

  // Monitor: pops the scoreboard on every result handshake.
  always @(negedge clock) begin
    exp_t e;
    if (last_pend) begin
      chk("in_ready_after_last", 128'(in_ready), 128'(1));
      last_pend = 1'b0;
    end
    if (res_valid && !rv_prev) rise_cyc = cyc;
    rv_prev = res_valid;
    if (res_valid && res_ready && !reset) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got data=%0h kernel=%0d",
                 res_data, res_kernel);
      end else begin
        e = sb.pop_front();
        chk("res_data", 128'(res_data), 128'(e.d));
        chk("res_kernel", 128'(res_kernel), 128'(e.k));
        chk("res_last", 128'(res_last), 128'(e.l));
        if (e.l) last_pend = 1'b1;
      end
    end
  end

  // Random consumer backpressure when enabled.
  always begin
    @(posedge clock);
    #1;
    if (rand_rdy) res_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int n;
    model_reset();
    reset = 1'b1;
    repeat (3) tick;
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_res_valid", 128'(res_valid), 128'(0));
    chk("rst_ctrl", 128'(op_ctrl_out), 128'(0));
    chk("rst_data", op_data_out, 128'(0));
    reset = 1'b0;
    tick;
    chk("post_rst_in_ready", 128'(in_ready), 128'(1));
    chk("post_rst_cfg_err", 128'(cfg_err), 128'(0));
    chk("post_rst_res_data", 128'(res_data), 128'(0));
    chk("post_rst_res_kernel", 128'(res_kernel), 128'(0));
    chk("post_rst_res_last", 128'(res_last), 128'(0));

    // Defaults, constant stub 100
    stub_const = 1'b1;
    stub_val   = 13'd100;
    res_ready  = 1'b1;
    send_frame(rnd128());
    chk("t1_ctrl_issue", 128'(op_ctrl_out), 128'(0));
    chk("t1_busy_issue", 128'(busy), 128'(1));
    wait_idle();
    chk("t1_latency", 128'(rise_cyc - acc_cyc), 128'(3));

    // Three kernels, constant stub 500
    cfg_idle(1'b1, 1, 32'h5555_5555, 1'b0, 0);
    cfg_idle(1'b1, 2, 32'hAAAA_AAAA, 1'b0, 0);
    cfg_idle(1'b0, 0, 32'h0, 1'b1, 3);
    stub_val = 13'd500;
    send_frame(rnd128());
    wait_idle();

    // Backpressure on first result
    res_ready = 1'b0;
    send_frame(rnd128());
    n = 0;
    while (!res_valid && n < 50) begin
      tick;
      n++;
    end
    if (!res_valid) fail_now("bp_valid_wait");
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_valid", 128'(res_valid), 128'(1));
      if (sb.size() > 0) begin
        chk("bp_data", 128'(res_data), 128'(sb[0].d));
        chk("bp_kernel", 128'(res_kernel), 128'(sb[0].k));
      end
      chk("bp_ctrl", 128'(op_ctrl_out), 128'(mw[0]));
      chk("bp_in_ready", 128'(in_ready), 128'(0));
    end
    res_ready = 1'b1;
    wait_idle();

    // Wrap: 16 negated taps on 0x1FFA
    cfg_idle(1'b1, 0, 32'hAAAA_AAAA, 1'b1, 1);
    stub_val = 13'h1FFA;
    send_frame(rnd128());
    wait_idle();

    // Illegal counts in IDLE
    cfg_idle(1'b0, 0, 32'h0, 1'b1, 0);
    tick;
    chk("err_pulse_width", 128'(cfg_err), 128'(0));
    cfg_idle(1'b0, 0, 32'h0, 1'b1, 5);

    // Config writes while busy are rejected
    stub_const = 1'b0;
    send_frame(rnd128());
    cfg_we     = 1'b1;
    cfg_kernel = '0;
    cfg_wdata  = 32'h1234_5678;
    cfg_nk_we  = 1'b1;
    cfg_nk     = 3'd2;
    tick;
    cfg_we    = 1'b0;
    cfg_nk_we = 1'b0;
    chk("busy_cfg_err", 128'(cfg_err), 128'(1));
    tick;
    chk("busy_cfg_err_drop", 128'(cfg_err), 128'(0));
    wait_idle();
    send_frame(rnd128());
    wait_idle();

    // Write forwarded in the accept cycle
    cfg_we     = 1'b1;
    cfg_kernel = '0;
    cfg_wdata  = 32'h5555_5555;
    cfg_nk_we  = 1'b1;
    cfg_nk     = 3'd2;
    mw[0] = 32'h5555_5555;
    mnk   = 2;
    send_frame(rnd128());
    chk("fwd_ctrl", 128'(op_ctrl_out), 128'(32'h5555_5555));
    wait_idle();

    // Random frames and configs with random backpressure
    rand_rdy = 1'b1;
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        wait_idle();
        cfg_idle(1'($urandom_range(0, 1)),
                 int'($urandom_range(0, NK - 1)), $urandom,
                 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 7)));
      end
      send_frame(rnd128());
    end
    wait_idle();
    rand_rdy  = 1'b0;
    res_ready = 1'b1;

    // Reset in WAIT with nk = 2
    cfg_idle(1'b1, 0, 32'hAAAA_5555, 1'b1, 2);
    send_frame(rnd128());
    tick;
    reset = 1'b1;
    tick;
    chk("mid_rst_in_ready", 128'(in_ready), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_valid", 128'(res_valid), 128'(0));
    chk("mid_rst_ctrl", 128'(op_ctrl_out), 128'(0));
    reset = 1'b0;
    sb.delete();
    model_reset();
    last_pend = 1'b0;
    #1;
    chk("mid_rst_ready_back", 128'(in_ready), 128'(1));
    send_frame(rnd128());
    chk("mid_rst_ctrl_x1", 128'(op_ctrl_out), 128'(0));
    wait_idle();
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
